apple_iie_timing: RTL
=====================

# apple_iie_timing

Master timing generator for the Fuji IIe motherboard, the stage directly upstream of the CPU and memory bus. From the 14.318 MHz reference it derives the 7M, Q3 and PHI0/PHI1/PHI2 clocks that drive the MCL65 core. It also produces the DRAM strobes (RAS_n, CAS_n, AX) and the horizontal/vertical scan counters that the video and memory-management stages consume. It implements the Apple IIe long-cycle rule: one stretched CPU cycle per scan line.

## Interface

Parameters:
- LINES_PER_FRAME, default 262: vertical scan lines per frame.
- VBL_START, default 192: first vertical-blank line.
- HBL_END, default 25: first visible horizontal count.

Ports:
- clk_14M  in  1  14.318 MHz clock; sole clock of the block.
- reset  in  1  asynchronous, active-high reset.
- clk_7M  out  1  14M divided by 2.
- clk_q3  out  1  2 MHz asymmetric strobe.
- clk_phi_0  out  1  CPU phase 0.
- clk_phi_1  out  1  inverse of clk_phi_0.
- clk_phi_2  out  1  copy of clk_phi_0.
- ras_n  out  1  DRAM row strobe.
- cas_n  out  1  DRAM column strobe.
- ax  out  1  high = row address selected.
- cycle_start  out  1  one-tick pulse at tick 0 of each CPU cycle.
- hcount  out  7  horizontal count, 0..64.
- vcount  out  9  vertical count, 0..LINES_PER_FRAME-1.
- hbl  out  1  high when hcount < HBL_END.
- vbl  out  1  high when vcount >= VBL_START.

## Operation

- The internal tick counter t spans 0..13 in a normal cycle and 0..15 in a long cycle. A cycle is long when hcount == 64.
- Every output is registered. On each clk_14M edge, outputs <= decode(t, long) and t <= next(t). Outputs therefore lag t by exactly one edge.
- The second half of a cycle starts at tick S, where S = 7 for a normal cycle and 9 for a long cycle. The cycle ends at tick E, where E = 13 for a normal cycle and 15 for a long cycle.
- Decode:
  - clk_phi_0 = 1 for t < S.
  - clk_q3 = 1 for t in 0..3 and S..S+3.
  - ras_n = 0 for t in 3..S-1 and S+3..E.
  - cas_n = 0 for t in 5..S-1 and S+5..E.
  - ax = 0 exactly where cas_n = 0.
  - cycle_start = 1 for t == 0.
- clk_7M toggles on every edge, independent of t. It does not skip or stretch during a long cycle.
- When t == E, t wraps to 0 and hcount advances. hcount 64 wraps to 0 and advances vcount. vcount LINES_PER_FRAME-1 wraps to 0.
- hcount, vcount, hbl and vbl are registered alongside the strobes and change on the same edge as cycle_start rising.

## Timing

- Reset (asynchronous):
  - Internal state: t = 0, hcount = 0, vcount = 0.
  - Outputs: clk_7M = 0, clk_q3 = 0, clk_phi_0 = 0, clk_phi_1 = 1, clk_phi_2 = 0, ras_n = 1, cas_n = 1, ax = 1, cycle_start = 0, hbl = 1, vbl = 0.
- First edge after reset deasserts: outputs show decode(0). clk_phi_0 = 1, clk_q3 = 1, cycle_start = 1, clk_7M = 1.
- Normal cycle: 14 ticks. Long cycle: 16 ticks. A line is 65 cycles = 912 ticks. A frame is 912 × LINES_PER_FRAME ticks.
- Reset asserted mid-cycle or mid-frame: all state and outputs return to reset values immediately. No partial cycle completes.
- Simultaneous wrap of t, hcount and vcount at frame end: all three go to 0 on the same edge, and the following cycle is normal.
- hcount == 64 is the only long cycle. Its cycle_start pulse is a single tick, the same as in a normal cycle.

## Configuration

- Macro TIMING_LONG_CYCLE_EN.
  - Defined: the long-cycle stretch operates as specified above.
  - Undefined: every cycle is 14 ticks (S = 7, E = 13), a line is 910 ticks, and hcount still counts 0..64. This mode is for simulation convenience and simplified targets.

## Structure

- Shared package fuji_iie_timing_pkg holds:
  - tick constants (normal S and E, long S and E, strobe start offsets);
  - HCOUNT_MAX = 64;
  - NTSC defaults for LINES_PER_FRAME, VBL_START and HBL_END.
- Natural sub-module: video_scan_counter, which implements hcount/vcount/hbl/vbl. It takes a cycle-end enable and exports the long-cycle flag.
- The tick counter and strobe decode stay in apple_iie_timing.

## Test plan

- Reset release: hold reset 5 ticks, then release. The first edge gives clk_phi_0 = 1, clk_q3 = 1, cycle_start = 1, ras_n = 1. cycle_start recurs every 14 ticks.
- Normal cycle shape: at hcount = 10, sample 14 edges. Required pattern: clk_phi_0 = 1111111 0000000; ras_n low at ticks 3–6 and 10–13; cas_n low at ticks 5–6 and 12–13.
- Long cycle: at hcount = 64, the cycle is 16 ticks with clk_phi_0 high for 9 ticks. clk_7M keeps toggling every edge. hcount then reads 0 and vcount increments.
- Line and frame length: count 912 ticks between hcount = 0 events. After 262 lines vcount wraps to 0. vbl rises exactly at vcount = 192; hbl falls at hcount = 25.
- Mid-operation reset: assert reset at hcount = 30, t = 9. Outputs go to reset values without waiting for an edge. After release, counters restart at 0.
- TIMING_LONG_CYCLE_EN undefined: every cycle is 14 ticks, including hcount = 64. The line length is 910 ticks.

Source files
------------

// File: rtl/fuji_iie_timing_pkg.sv
// Shared tick constants, scan defaults and strobe decode for the IIe timing generator.
// TIMING_LONG_CYCLE_EN selects whether hcount 64 stretches its CPU cycle.
package fuji_iie_timing_pkg;

    localparam logic [4:0] T_S_NORM = 5'd7;
    localparam logic [4:0] T_E_NORM = 5'd13;
    localparam logic [4:0] T_S_LONG = 5'd9;
    localparam logic [4:0] T_E_LONG = 5'd15;

    localparam logic [4:0] Q3_LEN  = 5'd4;
    localparam logic [4:0] RAS_OFS = 5'd3;
    localparam logic [4:0] CAS_OFS = 5'd5;

    localparam logic [6:0] HCOUNT_MAX = 7'd64;

    localparam int NTSC_LINES_PER_FRAME = 262;
    localparam int NTSC_VBL_START       = 192;
    localparam int NTSC_HBL_END         = 25;

    typedef struct packed {
        logic phi0;
        logic q3;
        logic ras_n;
        logic cas_n;
        logic start;
    } strobe_t;

    function automatic strobe_t tick_decode(
        input logic [3:0] t,
        input logic       long_cyc
    );
        strobe_t    d;
        logic [4:0] tt;
        logic [4:0] s;
        logic [4:0] e;
        tt = {1'b0, t};
        s  = long_cyc ? T_S_LONG : T_S_NORM;
        e  = long_cyc ? T_E_LONG : T_E_NORM;
        d.phi0  = (tt < s);
        d.q3    = (tt < Q3_LEN) ||
                  ((tt >= s) && (tt < s + Q3_LEN));
        d.ras_n = !(((tt >= RAS_OFS) && (tt < s)) ||
                    ((tt >= s + RAS_OFS) && (tt <= e)));
        d.cas_n = !(((tt >= CAS_OFS) && (tt < s)) ||
                    ((tt >= s + CAS_OFS) && (tt <= e)));
        d.start = (tt == 5'd0);
        return d;
    endfunction

endpackage

// File: rtl/video_scan_counter.sv
// Horizontal/vertical scan counters and blanking flags, advanced once per CPU cycle.
// With TIMING_LONG_CYCLE_EN defined, flags hcount 64 as the long cycle.
module video_scan_counter
    import fuji_iie_timing_pkg::*;
#(
    parameter int LINES_PER_FRAME = NTSC_LINES_PER_FRAME,
    parameter int VBL_START       = NTSC_VBL_START,
    parameter int HBL_END         = NTSC_HBL_END
) (
    input  logic       clk_14M,
    input  logic       reset,
    input  logic       cycle_end,
    output logic       long_cycle,
    output logic [6:0] hcount,
    output logic [8:0] vcount,
    output logic       hbl,
    output logic       vbl
);

    logic [6:0] h;
    logic [8:0] v;

`ifdef TIMING_LONG_CYCLE_EN
    assign long_cycle = (h == HCOUNT_MAX);
`else
    assign long_cycle = 1'b0;
`endif

    // Internal position advances on the last tick of each CPU cycle.
    always_ff @(posedge clk_14M or posedge reset) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (cycle_end) begin
            if (h == HCOUNT_MAX) begin
                h <= '0;
                if (v == 9'(LINES_PER_FRAME - 1))
                    v <= '0;
                else
                    v <= v + 9'd1;
            end else begin
                h <= h + 7'd1;
            end
        end
    end

    // Registered copies lag one edge so they change with cycle_start.
    always_ff @(posedge clk_14M or posedge reset) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
            hbl    <= 1'b1;
            vbl    <= 1'b0;
        end else begin
            hcount <= h;
            vcount <= v;
            hbl    <= (h < 7'(HBL_END));
            vbl    <= (v >= 9'(VBL_START));
        end
    end

endmodule

// File: rtl/apple_iie_timing.sv
// Fuji IIe master timing: CPU clocks, DRAM strobes and scan counters from 14M.
// TIMING_LONG_CYCLE_EN enables the 16-tick stretch at hcount 64.
module apple_iie_timing
    import fuji_iie_timing_pkg::*;
#(
    parameter int LINES_PER_FRAME = NTSC_LINES_PER_FRAME,
    parameter int VBL_START       = NTSC_VBL_START,
    parameter int HBL_END         = NTSC_HBL_END
) (
    input  logic       clk_14M,
    input  logic       reset,
    output logic       clk_7M,
    output logic       clk_q3,
    output logic       clk_phi_0,
    output logic       clk_phi_1,
    output logic       clk_phi_2,
    output logic       ras_n,
    output logic       cas_n,
    output logic       ax,
    output logic       cycle_start,
    output logic [6:0] hcount,
    output logic [8:0] vcount,
    output logic       hbl,
    output logic       vbl
);

    logic [3:0] t;
    logic [4:0] t_end;
    logic       long_cycle;
    logic       cycle_end;
    strobe_t    dec;

    // Cycle end point and strobe pattern for the current tick.
    always_comb begin
        t_end     = long_cycle ? T_E_LONG : T_E_NORM;
        cycle_end = ({1'b0, t} == t_end);
        dec       = tick_decode(t, long_cycle);
    end

    // Tick counter within the CPU cycle.
    always_ff @(posedge clk_14M or posedge reset) begin
        if (reset)
            t <= '0;
        else if (cycle_end)
            t <= '0;
        else
            t <= t + 4'd1;
    end

    // Registered clocks and strobes, one edge behind the tick counter.
    always_ff @(posedge clk_14M or posedge reset) begin
        if (reset) begin
            clk_7M      <= 1'b0;
            clk_q3      <= 1'b0;
            clk_phi_0   <= 1'b0;
            clk_phi_1   <= 1'b1;
            clk_phi_2   <= 1'b0;
            ras_n       <= 1'b1;
            cas_n       <= 1'b1;
            ax          <= 1'b1;
            cycle_start <= 1'b0;
        end else begin
            clk_7M      <= ~clk_7M;
            clk_q3      <= dec.q3;
            clk_phi_0   <= dec.phi0;
            clk_phi_1   <= ~dec.phi0;
            clk_phi_2   <= dec.phi0;
            ras_n       <= dec.ras_n;
            cas_n       <= dec.cas_n;
            ax          <= dec.cas_n;
            cycle_start <= dec.start;
        end
    end

    video_scan_counter #(
        .LINES_PER_FRAME(LINES_PER_FRAME),
        .VBL_START      (VBL_START),
        .HBL_END        (HBL_END)
    ) u_scan (
        .clk_14M   (clk_14M),
        .reset     (reset),
        .cycle_end (cycle_end),
        .long_cycle(long_cycle),
        .hcount    (hcount),
        .vcount    (vcount),
        .hbl       (hbl),
        .vbl       (vbl)
    );

endmodule
